// File: rtl/key_debounce_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : key_debounce_fsm
// Purpose  : Debounce receiver for a bouncing, active-low mechanical key.
//            The raw key is synchronised through two flops. A 4-state FSM
//            with a stability counter then accepts press and release edges
//            only after the synchronised key has been stable long enough.
//            Outputs are a debounced level plus one-cycle press, release and
//            long-press pulses.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CNT_MAX     cycles key_sync must be stable before an edge is accepted (>= 2)
//   LONG_MAX    cycles held down before key_long fires (>= 2)
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   key_in      raw asynchronous key, 0 = pressed
//   key_state   debounced level, 1 = released, 0 = pressed
//   key_press   one-cycle pulse on an accepted press
//   key_release one-cycle pulse on an accepted release
//   key_long    one-cycle pulse after LONG_MAX cycles held, once per press
// ============================================================================
module key_debounce_fsm #(
    parameter int CNT_MAX  = 1_000_000,
    parameter int LONG_MAX = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int C_CNT_W  = ($clog2(CNT_MAX)  > 0) ? $clog2(CNT_MAX)  : 1;
    localparam int C_LCNT_W = ($clog2(LONG_MAX) > 0) ? $clog2(LONG_MAX) : 1;

    localparam logic [C_CNT_W-1:0]  C_CNT_LAST  = C_CNT_W'(CNT_MAX - 1);
    localparam logic [C_LCNT_W-1:0] C_LCNT_LAST = C_LCNT_W'(LONG_MAX - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILTER_DN = 2'd1,
        DOWN      = 2'd2,
        FILTER_UP = 2'd3
    } state_t;

    // Synchroniser
    logic r_s0;
    logic r_key_sync;

    // FSM and counters
    state_t              r_state,     w_state;
    logic [C_CNT_W-1:0]  r_cnt,       w_cnt;
    logic [C_LCNT_W-1:0] r_lcnt,      w_lcnt;
    logic                r_long_done, w_long_done;

    // Registered outputs
    logic r_key_state, w_key_state;
    logic r_press,     w_press;
    logic r_release,   w_release;
    logic r_long,      w_long;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0        <= 1'b1;
            r_key_sync  <= 1'b1;
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_lcnt      <= '0;
            r_long_done <= 1'b0;
            r_key_state <= 1'b1;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long      <= 1'b0;
        end else begin
            r_s0        <= key_in;
            r_key_sync  <= r_s0;
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_lcnt      <= w_lcnt;
            r_long_done <= w_long_done;
            r_key_state <= w_key_state;
            r_press     <= w_press;
            r_release   <= w_release;
            r_long      <= w_long;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_lcnt      = r_lcnt;
        w_long_done = r_long_done;
        w_key_state = r_key_state;
        w_press     = 1'b0;
        w_release   = 1'b0;
        w_long      = 1'b0;

        // The long-press timer runs while the key is held, including any
        // release bounce, so bounce never stretches the long-press time.
        // It saturates at its last value; r_long_done keeps the pulse single.
        if (r_state == DOWN || r_state == FILTER_UP) begin
            if (r_lcnt == C_LCNT_LAST) begin
                if (!r_long_done) begin
                    w_long      = 1'b1;
                    w_long_done = 1'b1;
                end
            end else begin
                w_lcnt = r_lcnt + 1'b1;
            end
        end

        case (r_state)
            IDLE: begin
                w_key_state = 1'b1;
                if (!r_key_sync) begin
                    w_state = FILTER_DN;
                    w_cnt   = '0;
                end
            end
            FILTER_DN: begin
                if (r_key_sync) begin
                    w_state = IDLE;
                    w_cnt   = '0;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state     = DOWN;
                    w_press     = 1'b1;
                    w_key_state = 1'b0;
                    w_lcnt      = '0;
                    w_long_done = 1'b0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            DOWN: begin
                if (r_key_sync) begin
                    w_state = FILTER_UP;
                    w_cnt   = '0;
                end
            end
            FILTER_UP: begin
                if (!r_key_sync) begin
                    w_state = DOWN;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state     = IDLE;
                    w_release   = 1'b1;
                    w_key_state = 1'b1;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign key_state   = r_key_state;
    assign key_press   = r_press;
    assign key_release = r_release;
    assign key_long    = r_long;

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_key_debounce_fsm
// Purpose  : Self-checking bench for key_debounce_fsm. Expected pulse cycles
//            are derived from the stimulus and queued; a monitor pops and
//            compares them as pulses appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_debounce_fsm;

    localparam int CNT_MAX  = 100;
    localparam int LONG_MAX = 1000;
    // key_in change driven after edge N: 2 sync flops, one IDLE/DOWN cycle,
    // then CNT_MAX filter cycles -> pulse registered on edge N+CNT_MAX+3.
    localparam int LAT      = CNT_MAX + 3;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic key_in = 1'b1;
    wire  key_state;
    wire  key_press;
    wire  key_release;
    wire  key_long;

    key_debounce_fsm #(
        .CNT_MAX  (CNT_MAX),
        .LONG_MAX (LONG_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int press_q[$];
    int rel_q[$];
    int long_q[$];

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance n edges, land 1 ns after the last one.
    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance until cyc reaches target, land 1 ns after that edge.
    task automatic wait_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulse monitor: every pulse cycle must match the queue head.
    always @(negedge clk) begin
        if (key_press === 1'b1 && key_release === 1'b1)
            chk("press_release_overlap", cyc, -1);
        if (key_press === 1'b1) begin
            if (press_q.size() == 0) chk("press_unexpected", cyc, -1);
            else                     chk("press_cycle", cyc, press_q.pop_front());
        end
        if (key_release === 1'b1) begin
            if (rel_q.size() == 0) chk("release_unexpected", cyc, -1);
            else                   chk("release_cycle", cyc, rel_q.pop_front());
        end
        if (key_long === 1'b1) begin
            if (long_q.size() == 0) chk("long_unexpected", cyc, -1);
            else                    chk("long_cycle", cyc, long_q.pop_front());
        end
    end

    initial begin
        #1_200_000;
        $display("FAIL watchdog: got cycle %0d want finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n, p, r;

        // 1. reset and idle
        rst = 1'b1; key_in = 1'b1;
        go(20);
        chk("rst_key_state", key_state, 1);
        chk("rst_press", key_press, 0);
        chk("rst_release", key_release, 0);
        chk("rst_long", key_long, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            go(500);
            chk("idle_key_state", key_state, 1);
        end

        // 2. clean press and release
        n = cyc; key_in = 1'b0; p = n + LAT; press_q.push_back(p);
        wait_to(p - 1); chk("clean_pre_press_state", key_state, 1);
        go(1);          chk("clean_post_press_state", key_state, 0);
        go(50);
        n = cyc; key_in = 1'b1; r = n + LAT; rel_q.push_back(r);
        wait_to(r - 1); chk("clean_pre_rel_state", key_state, 0);
        go(1);          chk("clean_post_rel_state", key_state, 1);
        wait_to(n + 300);

        // 3. bounce on press (held past the long-press point) and release
        for (int i = 0; i < 50; i++) begin
            key_in = ~key_in;
            go($urandom_range(1, 99));
        end
        n = cyc; key_in = 1'b0; p = n + LAT;
        press_q.push_back(p);
        long_q.push_back(p + LONG_MAX);
        wait_to(p + LONG_MAX + 100);
        chk("bounce_held_state", key_state, 0);
        for (int i = 0; i < 50; i++) begin
            key_in = ~key_in;
            go($urandom_range(1, 99));
        end
        n = cyc; key_in = 1'b1; r = n + LAT; rel_q.push_back(r);
        wait_to(r + 10);
        chk("bounce_released_state", key_state, 1);

        // 4. glitches: 99 cycles rejected, 101 cycles accepted
        key_in = 1'b0; go(99); key_in = 1'b1;
        go(300);
        chk("glitch99_state", key_state, 1);
        n = cyc; key_in = 1'b0;
        press_q.push_back(n + LAT);
        go(101); key_in = 1'b1;
        rel_q.push_back(n + 101 + LAT);
        wait_to(n + LAT);
        chk("glitch101_pressed_state", key_state, 0);
        wait_to(n + 101 + LAT + 10);
        chk("glitch101_released_state", key_state, 1);

        // 5. long press with a short release bounce mid-hold
        n = cyc; key_in = 1'b0; p = n + LAT;
        press_q.push_back(p);
        long_q.push_back(p + LONG_MAX);
        wait_to(p + 400);
        key_in = 1'b1; go(50); key_in = 1'b0;
        wait_to(p + LONG_MAX - 1); chk("long_before", key_long, 0);
        go(1);                     chk("long_at", key_long, 1);
        go(1);                     chk("long_after", key_long, 0);
        wait_to(p + 1500);
        chk("long_held_state", key_state, 0);
        n = cyc; key_in = 1'b1; rel_q.push_back(n + LAT);
        wait_to(n + LAT + 20);
        chk("long_released_state", key_state, 1);

        // 6. reset in the middle of press filtering (cnt = 60)
        n = cyc; key_in = 1'b0;
        wait_to(n + 63);
        rst = 1'b1;
        go(5);
        chk("midrst_key_state", key_state, 1);
        chk("midrst_press", key_press, 0);
        rst = 1'b0;
        n = cyc; press_q.push_back(n + LAT);
        wait_to(n + LAT - 1); chk("midrst_pre_press_state", key_state, 1);
        go(1);                chk("midrst_post_press_state", key_state, 0);
        go(20);
        n = cyc; key_in = 1'b1; rel_q.push_back(n + LAT);
        wait_to(n + LAT + 20);
        chk("midrst_released_state", key_state, 1);

        go(10);
        chk("press_left", press_q.size(), 0);
        chk("release_left", rel_q.size(), 0);
        chk("long_left", long_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
